// File: rtl/text_renderer.sv
// Character-cell text renderer: walks a character buffer and a font ROM to emit a
// serial pixel stream with inverse attribute, scroll origin and blinking cursor.
module text_renderer #(
  parameter int ROWS         = 25,
  parameter int COLS         = 80,
  parameter int CHAR_W       = 8,
  parameter int CHAR_H       = 16,
  parameter int ROW_BITS     = 5,
  parameter int COL_BITS     = 7,
  parameter int ADDR_BITS    = 11,
  parameter int CHAR_H_BITS  = 4,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                     clk,
  input  logic                     clr_n,
  input  logic                     hblank,
  input  logic                     vblank,
  output logic [ADDR_BITS-1:0]     buf_addr,
  input  logic [7:0]               buf_data,
  output logic [CHAR_H_BITS+6:0]   font_addr,
  input  logic [7:0]               font_data,
  input  logic [ADDR_BITS-1:0]     first_char,
  input  logic                     first_char_wen,
  input  logic [ROW_BITS-1:0]      cursor_row,
  input  logic [COL_BITS-1:0]      cursor_col,
  input  logic                     cursor_en,
  input  logic                     cursor_blink,
  output logic                     pixel_out,
  output logic                     blank_out
);

  localparam int                     BlinkW    = $clog2(BLINK_FRAMES) + 1;
  localparam logic [ROW_BITS-1:0]    RowsL     = ROW_BITS'(ROWS);
  localparam logic [COL_BITS-1:0]    ColsL     = COL_BITS'(COLS);
  localparam logic [2:0]             ColcLast  = 3'(CHAR_W - 1);
  localparam logic [CHAR_H_BITS-1:0] RowcLast  = CHAR_H_BITS'(CHAR_H - 1);
  localparam logic [ADDR_BITS-1:0]   CharLast  = ADDR_BITS'(ROWS * COLS - 1);
  localparam logic [BlinkW-1:0]      BlinkLast = BlinkW'(BLINK_FRAMES - 1);

  logic [2:0]             colc_q, colc_d;
  logic [COL_BITS-1:0]    col_q, col_d;
  logic [CHAR_H_BITS-1:0] rowc_q, rowc_d;
  logic [ROW_BITS-1:0]    row_q, row_d;
  logic [ADDR_BITS-1:0]   char_q, char_d;
  logic [ADDR_BITS-1:0]   lineStart_q, lineStart_d;
  logic [ADDR_BITS-1:0]   pendingFirst_q, pendingFirst_d;
  logic [ADDR_BITS-1:0]   frameFirst_q, frameFirst_d;
  logic [BlinkW-1:0]      blinkCnt_q, blinkCnt_d;
  logic                   blinkPhase_q, blinkPhase_d;
  logic                   frameValid_q, frameValid_d;
  logic                   wasActive_q, vblankPrev_q;

  logic                   inRange, blank0, hit0;
  logic [CHAR_H_BITS-1:0] rowcS1_q;
  logic [2:0]             colcS1_q, colcS2_q;
  logic                   blankS1_q, blankS2_q, hitS1_q, hitS2_q, attrS2_q;
  logic                   pixel_q, blankOut_q;

  assign inRange  = (col_q < ColsL) && (row_q < RowsL);
  // frameValid_q keeps the screen dark after a reset until a full vblank has re-seeded the counters
  assign blank0   = hblank | vblank | ~inRange | ~frameValid_q;
  assign hit0     = cursor_en & (row_q == cursor_row) & (col_q == cursor_col) &
                    (blinkPhase_q | ~cursor_blink);
  assign buf_addr = char_q;
  assign font_addr = {buf_data[6:0], rowcS1_q};

  always_comb begin
    colc_d         = colc_q;
    col_d          = col_q;
    rowc_d         = rowc_q;
    row_d          = row_q;
    char_d         = char_q;
    lineStart_d    = lineStart_q;
    frameFirst_d   = frameFirst_q;
    frameValid_d   = frameValid_q;
    blinkCnt_d     = blinkCnt_q;
    blinkPhase_d   = blinkPhase_q;
    pendingFirst_d = first_char_wen ? first_char : pendingFirst_q;

    if (vblank) begin
      frameFirst_d = pendingFirst_d;
      colc_d       = '0;
      col_d        = '0;
      rowc_d       = '0;
      row_d        = '0;
      char_d       = pendingFirst_d;
      lineStart_d  = pendingFirst_d;
      frameValid_d = 1'b1;
    end else if (!hblank) begin
      if (inRange) begin
        if (colc_q == ColcLast) begin
          colc_d = '0;
          col_d  = col_q + 1'b1;
          char_d = (char_q == CharLast) ? '0 : char_q + 1'b1;
        end else begin
          colc_d = colc_q + 1'b1;
        end
      end
    end else if (wasActive_q) begin
      // End of a scanline: rewind to the row start unless the glyph cell is finished
      colc_d = '0;
      col_d  = '0;
      if (rowc_q == RowcLast) begin
        rowc_d      = '0;
        row_d       = (row_q < RowsL) ? row_q + 1'b1 : row_q;
        lineStart_d = char_q;
      end else begin
        rowc_d = rowc_q + 1'b1;
        char_d = lineStart_q;
      end
    end

    if (vblank && !vblankPrev_q) begin
      if (blinkCnt_q == BlinkLast) begin
        blinkCnt_d   = '0;
        blinkPhase_d = ~blinkPhase_q;
      end else begin
        blinkCnt_d = blinkCnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      colc_q         <= '0;
      col_q          <= '0;
      rowc_q         <= '0;
      row_q          <= '0;
      char_q         <= '0;
      lineStart_q    <= '0;
      pendingFirst_q <= '0;
      frameFirst_q   <= '0;
      blinkCnt_q     <= '0;
      blinkPhase_q   <= 1'b0;
      frameValid_q   <= 1'b0;
      wasActive_q    <= 1'b0;
      vblankPrev_q   <= 1'b0;
    end else begin
      colc_q         <= colc_d;
      col_q          <= col_d;
      rowc_q         <= rowc_d;
      row_q          <= row_d;
      char_q         <= char_d;
      lineStart_q    <= lineStart_d;
      pendingFirst_q <= pendingFirst_d;
      frameFirst_q   <= frameFirst_d;
      blinkCnt_q     <= blinkCnt_d;
      blinkPhase_q   <= blinkPhase_d;
      frameValid_q   <= frameValid_d;
      wasActive_q    <= ~hblank & ~vblank;
      vblankPrev_q   <= vblank;
    end
  end

  // Three-stage pixel pipeline matching the buffer and font read latencies
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      rowcS1_q   <= '0;
      colcS1_q   <= '0;
      colcS2_q   <= '0;
      blankS1_q  <= 1'b1;
      blankS2_q  <= 1'b1;
      hitS1_q    <= 1'b0;
      hitS2_q    <= 1'b0;
      attrS2_q   <= 1'b0;
      pixel_q    <= 1'b0;
      blankOut_q <= 1'b1;
    end else begin
      rowcS1_q   <= rowc_q;
      colcS1_q   <= colc_q;
      blankS1_q  <= blank0;
      hitS1_q    <= hit0;
      colcS2_q   <= colcS1_q;
      blankS2_q  <= blankS1_q;
      hitS2_q    <= hitS1_q;
      attrS2_q   <= buf_data[7];
      pixel_q    <= ~blankS2_q & (font_data[3'd7 - colcS2_q] ^ attrS2_q ^ hitS2_q);
      blankOut_q <= blankS2_q;
    end
  end

  assign pixel_out = pixel_q;
  assign blank_out = blankOut_q;

endmodule

// File: tb/tb_text_renderer.sv
// Self-checking bench for text_renderer: directed vectors against a behavioural
// buffer/font memory, plus scroll, rewind, cursor blink and reset sequences.
module tb_text_renderer;

  logic        clk = 1'b0;
  logic        clr_n, hblank, vblank, first_char_wen, cursor_en, cursor_blink;
  logic [10:0] buf_addr, first_char, font_addr;
  logic [7:0]  buf_data, font_data;
  logic [4:0]  cursor_row;
  logic [6:0]  cursor_col;
  logic        pixel_out, blank_out;

  logic [7:0]  bufMem  [0:2047];
  logic [7:0]  fontMem [0:2047];

  logic        pixLog  [0:65535];
  logic        blkLog  [0:65535];
  logic [10:0] addrLog [0:65535];
  int          cyc, total, bad, vbEdges, wenLine, ls, errCnt;
  int          lineStart [0:63];
  logic [7:0]  pixByte;
  logic        flag;

  typedef struct {
    logic [7:0] bufByte;
    logic [7:0] fontRow;
    logic [7:0] expPix;
  } vec_t;
  vec_t vecs [0:5];

  text_renderer #(.BLINK_FRAMES(2)) dut (
    .clk(clk), .clr_n(clr_n), .hblank(hblank), .vblank(vblank),
    .buf_addr(buf_addr), .buf_data(buf_data), .font_addr(font_addr), .font_data(font_data),
    .first_char(first_char), .first_char_wen(first_char_wen),
    .cursor_row(cursor_row), .cursor_col(cursor_col), .cursor_en(cursor_en),
    .cursor_blink(cursor_blink), .pixel_out(pixel_out), .blank_out(blank_out)
  );

  always #5 clk = ~clk;

  // Synchronous memories: data valid the cycle after the address
  always @(posedge clk) begin
    buf_data  <= bufMem[buf_addr];
    font_data <= fontMem[font_addr];
  end

  task tick();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc < 65536) begin
      pixLog[cyc]  = pixel_out;
      blkLog[cyc]  = blank_out;
      addrLog[cyc] = buf_addr;
    end
  endtask

  task checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One frame: short vblank, then nLines lines of actLen active and hbLen blanking cycles
  task applyStimulus(input int nLines, input int actLen, input int hbLen);
    vblank = 1'b1;
    hblank = 1'b1;
    vbEdges++;
    repeat (4) tick();
    vblank = 1'b0;
    for (int l = 0; l < nLines; l++) begin
      hblank = 1'b0;
      lineStart[l] = cyc;
      for (int k = 0; k < actLen; k++) begin
        first_char_wen = (l == wenLine) && (k == 100);
        tick();
      end
      first_char_wen = 1'b0;
      hblank = 1'b1;
      repeat (hbLen) tick();
    end
  endtask

  function automatic logic [7:0] getByte(input int base);
    logic [7:0] b;
    for (int k = 0; k < 8; k++) b[7-k] = pixLog[base + 3 + k];
    return b;
  endfunction

  initial begin
    vecs[0] = '{8'h41, 8'h18, 8'h18};
    vecs[1] = '{8'hC1, 8'h18, 8'hE7};
    vecs[2] = '{8'h42, 8'hA5, 8'hA5};
    vecs[3] = '{8'h80, 8'h00, 8'hFF};
    vecs[4] = '{8'h7F, 8'h81, 8'h81};
    vecs[5] = '{8'hFF, 8'h0F, 8'hF0};

    clr_n = 1'b0; hblank = 1'b1; vblank = 1'b0; first_char = '0; first_char_wen = 1'b0;
    cursor_en = 1'b0; cursor_blink = 1'b0; cursor_row = 5'd2; cursor_col = 7'd5;
    cyc = 0; total = 0; bad = 0; vbEdges = 0; wenLine = -1;
    for (int i = 0; i < 2048; i++) begin
      bufMem[i]  = 8'h00;
      fontMem[i] = 8'h00;
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_pixel", pixel_out, 0);
    checkOutput("reset_blank", blank_out, 1);
    checkOutput("reset_addr", buf_addr, 0);
    clr_n = 1'b1;
    repeat (2) tick();

    // Single glyph row, attribute and font combinations
    for (int v = 0; v < 6; v++) begin
      bufMem[0] = vecs[v].bufByte;
      fontMem[{vecs[v].bufByte[6:0], 4'd0}] = vecs[v].fontRow;
      applyStimulus(1, 16, 8);
      ls = lineStart[0];
      checkOutput($sformatf("vec%0d_pixels", v), getByte(ls), vecs[v].expPix);
      flag = 1'b0;
      for (int k = 0; k < 8; k++) flag |= blkLog[ls + 3 + k];
      checkOutput($sformatf("vec%0d_active_blank", v), flag, 0);
      flag = 1'b0;
      for (int k = 0; k < 5; k++) flag |= pixLog[ls + 19 + k] | ~blkLog[ls + 19 + k];
      checkOutput($sformatf("vec%0d_hblank_dark", v), flag, 0);
    end

    // Scanline rewind, column saturation and out-of-range blanking
    for (int i = 0; i < 2048; i++) bufMem[i] = 8'hC1;
    applyStimulus(17, 660, 8);
    for (int l = 0; l < 16; l += 15) begin
      checkOutput($sformatf("rewind_l%0d_first", l), addrLog[lineStart[l]], 0);
      checkOutput($sformatf("rewind_l%0d_last", l), addrLog[lineStart[l] + 8*79], 79);
    end
    checkOutput("rewind_l16_first", addrLog[lineStart[16]], 80);
    checkOutput("rewind_l16_col10", addrLog[lineStart[16] + 80], 90);
    checkOutput("sat_addr", addrLog[lineStart[0] + 650], 80);
    checkOutput("col79_pixel", pixLog[lineStart[0] + 642], 1);
    checkOutput("col79_blank", blkLog[lineStart[0] + 642], 0);
    checkOutput("col80_pixel", pixLog[lineStart[0] + 643], 0);
    checkOutput("col80_blank", blkLog[lineStart[0] + 643], 1);

    // Scroll origin written mid-frame takes effect on the next frame only
    first_char = 11'd1990;
    wenLine = 0;
    applyStimulus(1, 660, 8);
    wenLine = -1;
    checkOutput("scroll_cur_c20", addrLog[lineStart[0] + 160], 20);
    checkOutput("scroll_cur_c79", addrLog[lineStart[0] + 632], 79);
    applyStimulus(1, 660, 8);
    checkOutput("scroll_next_c0", addrLog[lineStart[0]], 1990);
    checkOutput("scroll_next_c9", addrLog[lineStart[0] + 72], 1999);
    checkOutput("scroll_next_c10", addrLog[lineStart[0] + 80], 0);
    checkOutput("scroll_next_c79", addrLog[lineStart[0] + 632], 69);

    // Cursor blink: phase toggles every second vblank rising edge
    for (int i = 0; i < 2048; i++) bufMem[i] = 8'h20;
    cursor_en = 1'b1;
    cursor_blink = 1'b1;
    for (int f = 0; f < 6; f++) begin
      applyStimulus(33, 48, 4);
      checkOutput($sformatf("blink_f%0d_cell", f), pixLog[lineStart[32] + 43], (vbEdges / 2) % 2);
      checkOutput($sformatf("blink_f%0d_left", f), pixLog[lineStart[32] + 35], 0);
    end
    cursor_blink = 1'b0;
    applyStimulus(33, 48, 4);
    checkOutput("steady_cell", pixLog[lineStart[32] + 43], 1);
    checkOutput("steady_row1", pixLog[lineStart[31] + 43], 0);
    cursor_en = 1'b0;
    for (int f = 0; f < 2; f++) begin
      applyStimulus(33, 48, 4);
      checkOutput($sformatf("cursor_off_f%0d", f), pixLog[lineStart[32] + 43], 0);
    end

    // Asynchronous reset in the middle of an active line
    for (int i = 0; i < 2048; i++) bufMem[i] = 8'hC1;
    vblank = 1'b1;
    hblank = 1'b1;
    repeat (4) tick();
    vblank = 1'b0;
    hblank = 1'b0;
    repeat (20) tick();
    #2 clr_n = 1'b0;
    #1;
    checkOutput("async_rst_pixel", pixel_out, 0);
    checkOutput("async_rst_blank", blank_out, 1);
    checkOutput("async_rst_addr", buf_addr, 0);
    #1 clr_n = 1'b1;
    errCnt = 0;
    for (int l = 0; l < 2; l++) begin
      hblank = 1'b0;
      for (int k = 0; k < 40; k++) begin
        tick();
        if (pixel_out || !blank_out) errCnt++;
      end
      hblank = 1'b1;
      for (int k = 0; k < 6; k++) begin
        tick();
        if (pixel_out || !blank_out) errCnt++;
      end
    end
    checkOutput("post_rst_dark", errCnt, 0);
    applyStimulus(1, 16, 8);
    checkOutput("post_rst_addr", addrLog[lineStart[0]], 0);
    checkOutput("post_rst_pixels", getByte(lineStart[0]), 8'hE7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
